task_injector_rx: RTL
=====================

# task_injector_rx

Receive stage that sits directly upstream of the task injector's service handler. It consumes the 32-bit flit stream from the NoC local port and frames each packet: target flit, size flit, HEADER_SIZE header words, then payload. It validates the service code in header word 0 against the injector's supported service set, presents the full header to the handler through a valid/ready handshake, and then forwards the payload as a flit stream. Packets with a malformed size or an unsupported service are drained and reported; nothing is presented to the handler.

## Interface
- HEADER_SIZE, 13, number of 32-bit header words per packet; header word 0 is the service code.
- clk_i  in  1  clock; every register is rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- flit_valid_i  in  1  inbound flit valid.
- flit_ready_o  out  1  inbound flit accepted when this and flit_valid_i are both high.
- flit_i  in  32  inbound flit data.
- hdr_valid_o  out  1  header, service and payload length are valid.
- hdr_ready_i  in  1  handler accepts the header.
- header_o  out  HEADER_SIZE*32  header words; word k occupies bits [32k+31:32k].
- service_o  out  32  copy of header word 0.
- payload_len_o  out  32  payload flit count, equal to size − HEADER_SIZE.
- payload_valid_o  out  1  payload flit valid.
- payload_ready_i  in  1  handler accepts a payload flit.
- payload_o  out  32  payload flit data (flit_i passed through).
- err_o  out  1  one-cycle pulse when a packet is discarded.
- err_code_o  out  2  discard cause, held until the next discard: 1 = size < HEADER_SIZE, 2 = unsupported service.

## Operation
- Packet format:
  - flit 0: target address. It is discarded and not checked.
  - flit 1: size N, the number of flits that follow.
  - next HEADER_SIZE flits: header.
  - remaining N − HEADER_SIZE flits: payload.
- Supported services: 0x00, 0x01, 0x10, 0x26, 0x31, 0x34, 0x40. Any other value of header word 0 is unsupported.
- State machine:
  - TARGET: flit_ready_o=1. On a handshake, go to SIZE.
  - SIZE: flit_ready_o=1. On a handshake:
    - Load rem = N.
    - If N == 0: pulse err_o, err_code=1, go to TARGET.
    - If 0 < N < HEADER_SIZE: err_code=1, go to DRAIN.
    - Otherwise: hdr_idx=0, go to HEADER.
  - HEADER: flit_ready_o=1. On each handshake:
    - Store the flit into header word hdr_idx, increment hdr_idx, decrement rem.
    - After the last header word, check the service:
      - Unsupported and rem ≠ 0: err_code=2, go to DRAIN.
      - Unsupported and rem == 0: pulse err_o, go to TARGET.
      - Supported: go to HDR_OUT.
  - HDR_OUT: flit_ready_o=0, hdr_valid_o=1. When hdr_ready_i is high, go to PAYLOAD if rem ≠ 0, otherwise to TARGET.
  - PAYLOAD:
    - payload_valid_o = flit_valid_i; flit_ready_o = payload_ready_i; payload_o = flit_i. These are combinational pass-throughs.
    - Each handshake decrements rem. On the handshake where rem == 1, go to TARGET.
  - DRAIN: flit_ready_o=1. Each handshake decrements rem. On the handshake where rem == 1, pulse err_o and go to TARGET.
- Error code timing: err_code_o updates on the same edge that enters DRAIN (or on the edge of the err_o pulse when no drain occurs).
- rem and payload_len_o are 32-bit unsigned. payload_len_o is registered on entry to HDR_OUT and held until the next header.
- header_o and service_o hold their values until overwritten by the next packet's header flits.

## Timing
- Reset values:
  - state = TARGET
  - flit_ready_o = 1
  - hdr_valid_o = 0
  - payload_valid_o = 0
  - err_o = 0
  - err_code_o = 0
  - header_o = 0, service_o = 0, payload_len_o = 0
  - rem = 0, hdr_idx = 0
- Throughput: one flit per cycle in TARGET, SIZE, HEADER and DRAIN.
- hdr_valid_o rises in the cycle after the last header flit handshake. It stays high, with all outputs stable, until hdr_ready_i is sampled high.
- No payload flit is accepted before the header handshake completes.
- Payload path has zero latency and no buffering. The handler must not create a combinational loop from payload_valid_o to payload_ready_i.
- err_o rises in the cycle after the final flit of the discarded packet and lasts exactly one cycle.
- Reset mid-packet returns immediately to TARGET with all outputs at reset values. Any partial packet is lost; the upstream must also be reset.
- Back-to-back packets: the target flit of the next packet may be accepted in the cycle after the last flit of the current packet.

## Test plan
- MESSAGE_DELIVERY (0x01) packet, N=16, three payload words 0xA, 0xB, 0xC, sink always ready -> hdr_valid_o one cycle after the 13th header flit; service_o=0x01; payload_len_o=3; payload_o delivers 0xA, 0xB, 0xC; state returns to TARGET.
- TASK_ALLOCATION (0x40) packet, N=13 (no payload), hdr_ready_i held low 5 cycles -> hdr_valid_o high 6 cycles; flit_ready_o=0 during the wait; no payload_valid_o; the next packet's target flit is accepted right after the handshake.
- N=5 (< 13) -> 5 flits drained; err_o pulses once; err_code_o=1; hdr_valid_o stays 0.
- Service 0x99, N=15 -> 2 payload flits drained; err_o pulse; err_code_o=2; hdr_valid_o stays 0.
- DATA_AV packet with 4 payload flits, payload_ready_i toggling every cycle and flit_valid_i randomised -> all 4 flits delivered exactly once, in order.
- rst_i asserted during the header of a first packet, then a clean APP_MAPPING_COMPLETE (0x34) packet sent -> every output at its reset value during reset; the second packet is received correctly.

Source files
------------

// File: rtl/task_injector_rx.sv
// Receive framer for the task injector: splits NoC packets into a validated header,
// which is presented through a valid/ready handshake, and a pass-through payload stream.
module task_injector_rx #(
    parameter int HEADER_SIZE = 13
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flit_valid_i,
    output logic                      flit_ready_o,
    input  logic [31:0]               flit_i,
    output logic                      hdr_valid_o,
    input  logic                      hdr_ready_i,
    output logic [HEADER_SIZE*32-1:0] header_o,
    output logic [31:0]               service_o,
    output logic [31:0]               payload_len_o,
    output logic                      payload_valid_o,
    input  logic                      payload_ready_i,
    output logic [31:0]               payload_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);

    localparam int IDX_W = $clog2(HEADER_SIZE + 1);

    typedef enum logic [2:0] {
        S_TARGET,
        S_SIZE,
        S_HEADER,
        S_HDR_OUT,
        S_PAYLOAD,
        S_DRAIN
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               rem_q, rem_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [HEADER_SIZE*32-1:0] header_q, header_d;
    logic [31:0]               len_q, len_d;
    logic                      err_q, err_d;
    logic [1:0]                code_q, code_d;
    logic                      flit_ready_s;
    logic                      flit_hs_s;
    logic                      last_hdr_s;
    logic [31:0]               svc_s;
    logic [31:0]               rem_dec_s;

    function automatic logic is_supported(input logic [31:0] svc);
        case (svc)
            32'h0000_0000, 32'h0000_0001, 32'h0000_0010, 32'h0000_0026,
            32'h0000_0031, 32'h0000_0034, 32'h0000_0040: is_supported = 1'b1;
            default:                                     is_supported = 1'b0;
        endcase
    endfunction

    // Inbound ready: the header wait blocks the link, payload follows the sink.
    always_comb begin
        flit_ready_s = 1'b0;
        case (state_q)
            S_TARGET:  flit_ready_s = 1'b1;
            S_SIZE:    flit_ready_s = 1'b1;
            S_HEADER:  flit_ready_s = 1'b1;
            S_HDR_OUT: flit_ready_s = 1'b0;
            S_PAYLOAD: flit_ready_s = payload_ready_i;
            S_DRAIN:   flit_ready_s = 1'b1;
            default:   flit_ready_s = 1'b0;
        endcase
    end

    assign flit_hs_s  = flit_valid_i & flit_ready_s;
    assign last_hdr_s = (idx_q == IDX_W'(HEADER_SIZE - 1));
    assign rem_dec_s  = rem_q - 32'd1;
    // Word 0 may still be on the wire when the header is a single word.
    assign svc_s      = (idx_q == IDX_W'(0)) ? flit_i : header_q[31:0];

    // Next-state, counters, header capture and discard reporting.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        header_d = header_q;
        len_d    = len_q;
        err_d    = 1'b0;
        code_d   = code_q;
        case (state_q)
            S_TARGET: begin
                if (flit_hs_s) begin
                    state_d = S_SIZE;
                end else begin
                    state_d = state_q;
                end
            end
            S_SIZE: begin
                if (flit_hs_s) begin
                    rem_d = flit_i;
                    if (flit_i == 32'd0) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_TARGET;
                    end else if (flit_i < 32'(HEADER_SIZE)) begin
                        code_d  = 2'd1;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d   = IDX_W'(0);
                        state_d = S_HEADER;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_HEADER: begin
                if (flit_hs_s) begin
                    for (int k = 0; k < HEADER_SIZE; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            header_d[k*32 +: 32] = flit_i;
                        end else begin
                            header_d[k*32 +: 32] = header_q[k*32 +: 32];
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    rem_d = rem_dec_s;
                    if (last_hdr_s) begin
                        if (!is_supported(svc_s)) begin
                            code_d = 2'd2;
                            if (rem_dec_s != 32'd0) begin
                                state_d = S_DRAIN;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_TARGET;
                            end
                        end else begin
                            len_d   = rem_dec_s;
                            state_d = S_HDR_OUT;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR_OUT: begin
                if (hdr_ready_i) begin
                    state_d = (rem_q != 32'd0) ? S_PAYLOAD : S_TARGET;
                end else begin
                    state_d = state_q;
                end
            end
            S_PAYLOAD: begin
                if (flit_hs_s) begin
                    rem_d   = rem_dec_s;
                    state_d = (rem_q == 32'd1) ? S_TARGET : S_PAYLOAD;
                end else begin
                    state_d = state_q;
                end
            end
            S_DRAIN: begin
                if (flit_hs_s) begin
                    rem_d = rem_dec_s;
                    if (rem_q == 32'd1) begin
                        err_d   = 1'b1;
                        state_d = S_TARGET;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_TARGET;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_TARGET;
            rem_q    <= 32'd0;
            idx_q    <= IDX_W'(0);
            header_q <= '0;
            len_q    <= 32'd0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            header_q <= header_d;
            len_q    <= len_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign flit_ready_o    = flit_ready_s;
    assign hdr_valid_o     = (state_q == S_HDR_OUT);
    assign header_o        = header_q;
    assign service_o       = header_q[31:0];
    assign payload_len_o   = len_q;
    assign payload_valid_o = (state_q == S_PAYLOAD) & flit_valid_i;
    assign payload_o       = (state_q == S_PAYLOAD) ? flit_i : 32'd0;
    assign err_o           = err_q;
    assign err_code_o      = code_q;

endmodule
